// File: rtl/johnson_run_ctrl.sv
// Johnson-code run controller: counts a 4-bit Johnson code for a requested number of steps.
// Optional build macro JOHNSON_SELF_CORRECT_EN replaces illegal preloads with 0000 and pulses err.
module johnson_run_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       start,
   input  logic [3:0] len,
   input  logic       stop,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] count_out,
   output logic [2:0] phase,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [3:0] count_r;
   logic [3:0] remaining_r;
   logic       err_r;
   logic       load_s;
   logic       start_ok_s;
   logic       step_s;
   logic [3:0] load_word_s;
   logic       load_err_s;

   function automatic logic is_legal(input logic [3:0] c);
      case (c)
         4'b0000, 4'b0001, 4'b0011, 4'b0111,
         4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] decode_phase(input logic [3:0] c);
      case (c)
         4'b0000: return 3'd0;
         4'b0001: return 3'd1;
         4'b0011: return 3'd2;
         4'b0111: return 3'd3;
         4'b1111: return 3'd4;
         4'b1110: return 3'd5;
         4'b1100: return 3'd6;
         4'b1000: return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [3:0] johnson_next(input logic [3:0] c);
      return {c[2:0], ~c[3]};
   endfunction

`ifdef JOHNSON_SELF_CORRECT_EN
   assign load_err_s  = ~is_legal(load_val);
   assign load_word_s = load_err_s ? 4'b0000 : load_val;
`else
   assign load_err_s  = 1'b0;
   assign load_word_s = load_val;
`endif

   // load wins over start; stop wins over stepping
   assign load_s     = (state_r == IDLE) && load;
   assign start_ok_s = (state_r == IDLE) && !load && start && en;
   assign step_s     = (state_r == RUN) && en && !stop;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               state_nxt_s = (len != 4'd0) ? RUN : DONE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (stop) begin
               state_nxt_s = DONE;
            end else if (en && (remaining_r == 4'd1)) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Code register, step counter and error pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r     <= 4'b0000;
         remaining_r <= 4'd0;
         err_r       <= 1'b0;
      end else begin
         err_r <= 1'b0;
         if (load_s) begin
            count_r <= load_word_s;
            err_r   <= load_err_s;
         end else if (start_ok_s) begin
            remaining_r <= len;
         end else if (step_s) begin
            count_r     <= johnson_next(count_r);
            remaining_r <= remaining_r - 4'd1;
         end
      end
   end

   // Output decode
   always_comb begin
      count_out = count_r;
      phase     = decode_phase(count_r);
      busy      = (state_r == RUN);
      done      = (state_r == DONE);
      err       = err_r;
   end

endmodule

// File: doc/johnson_run_ctrl.md
JOHNSON_RUN_CTRL -- requirements
Module: johnson_run_ctrl

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global step enable; when low, the run is frozen.
- start  input  1  run request; sampled in IDLE only.
- len  input  4  number of steps for a run (0-15); sampled with start.
- stop  input  1  abort request; honoured in RUN only.
- load  input  1  preload request; honoured in IDLE only.
- load_val  input  4  preload pattern for count_out.
- count_out  output  4  Johnson code register.
- phase  output  3  decoded phase index of count_out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at the end of a run.
- err  output  1  one-cycle pulse on an illegal preload (see Configuration).

Function
REQ-002 SHALL implement the FSM states IDLE, RUN and DONE; busy SHALL equal (state==RUN).
REQ-003 In IDLE, start=1 with en=1 and len!=0 SHALL enter RUN on the next edge and latch remaining=len.
REQ-004 In IDLE, start=1 with en=1 and len==0 SHALL enter DONE with no step.
REQ-005 start with en=0 SHALL be ignored.
REQ-006 In RUN with en=1 and stop=0, each edge SHALL step: count_out <= {count_out[2:0], ~count_out[3]}, and remaining SHALL decrement by 1.
REQ-007 The step that brings remaining from 1 to 0 SHALL also move the FSM to DONE.
REQ-008 In RUN with en=0, count_out, remaining and state SHALL all hold.
REQ-009 In RUN, stop=1 SHALL move the FSM to DONE on that edge with no step, regardless of en.
REQ-010 In RUN, start and load SHALL be ignored.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE; count_out SHALL hold.
REQ-012 In IDLE, when load=1 and start=1 in the same cycle, load SHALL take effect and start SHALL be ignored.
REQ-013 In IDLE, load=1 SHALL write load_val into count_out on the next edge, independent of en.
REQ-014 The code sequence SHALL wrap: 0000,0001,0011,0111,1111,1110,1100,1000, then 0000.
REQ-015 phase SHALL be a combinational decode of count_out to the values 0..7 in the order of REQ-014; any illegal code SHALL decode to 0.
REQ-016 Latency from start to the first step SHALL be 2 edges: the first edge enters RUN, the second edge steps.
REQ-017 A run of N steps SHALL produce done exactly N+1 cycles after start was accepted, provided en stays high.

Reset
REQ-018 On reset=1 at a clock edge, the block SHALL enter IDLE with count_out=0000, remaining=0, busy=0, done=0 and err=0.
REQ-019 Reset mid-run SHALL abort the run without asserting done.
REQ-020 reset SHALL have priority over every other input.

Configuration
REQ-021 Macro JOHNSON_SELF_CORRECT_EN defined: a load whose load_val is not one of the 8 legal codes SHALL load 0000 instead and pulse err for one cycle.
REQ-022 Macro JOHNSON_SELF_CORRECT_EN undefined: load_val SHALL be loaded as-is and err SHALL be tied to 0; stepping an illegal code SHALL follow the same shift rule as REQ-006.

Verification
REQ-023 Reset, then start=1 with len=3 and en held high: count_out SHALL go 0001, 0011, 0111, and done SHALL pulse 4 cycles after start was accepted.
REQ-024 Start with len=10 from 0000: count_out SHALL wrap through 1000 to 0000 and end at 0011; phase SHALL track 1..7, 0, 1, 2.
REQ-025 Start with len=8, en=0 for 3 cycles mid-run, then stop=1 after 4 steps: the run SHALL freeze while en=0, end at 1111 with no further step, and done SHALL pulse once.
REQ-026 load=1 with load_val=0101: with JOHNSON_SELF_CORRECT_EN, count_out SHALL become 0000 and err SHALL pulse; without it, count_out SHALL become 0101, phase SHALL be 0 and err SHALL stay 0.
REQ-027 Start with len=0: done SHALL pulse with no step; asserting reset during a len=6 run SHALL give count_out=0000, busy=0 and no done pulse.
